// File: rtl/better_neighbor_writer.sv
// better_neighbor_writer
// Scans the neighbor ID / Q-value tables in shared node memory. It writes the ID of
// every neighbor whose Q-value strictly exceeds the latched threshold into the
// better-neighbor list, then writes the entry count and pulses done.
// Optional feature macro: BETTER_NEIGHBOR_SELF_FILTER_EN (when defined, the node's
// own ID is never listed).
module better_neighbor_writer #(
   parameter logic [15:0] ID_BASE     = 16'h0600,
   parameter logic [15:0] Q_BASE      = 16'h0620,
   parameter logic [15:0] LIST_BASE   = 16'h0668,
   parameter logic [15:0] COUNT_ADDR  = 16'h068C,
   parameter int          MAX_ENTRIES = 16
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic        start_betterNeighbor,
   input  logic [15:0] neighbor_count,
   input  logic [15:0] _mybest,
   input  logic [15:0] MY_NODE_ID,
   input  logic [15:0] data_in,
   output logic [15:0] address,
   output logic [15:0] data_out,
   output logic        wr_en,
   output logic        done_betterNeighbor,
   output logic [7:0]  cstate
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_RD_ID  = 4'd1,
      S_CAP_ID = 4'd2,
      S_RD_Q   = 4'd3,
      S_CAP_Q  = 4'd4,
      S_EVAL   = 4'd5,
      S_WR_ENT = 4'd6,
      S_WR_CNT = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   // The scan length is clamped to the table size; the list capacity is separate.
   localparam logic [4:0] NBR_MAX = 5'd16;
   localparam logic [4:0] MAX_K   = 5'(MAX_ENTRIES);

   state_t      state_q;
   logic [4:0]  i_q, k_q, n_q;
   logic [15:0] thr_q, id_q, qv_q;
   logic [15:0] addr_q, dout_q;
   logic        wr_q, done_q;

   logic [4:0]  n_clamp_d, i_inc_d, k_inc_d;
   logic        last_d, qualify_d;

`ifdef BETTER_NEIGHBOR_SELF_FILTER_EN
   logic [15:0] me_q;
`else
   // Own node ID plays no part in qualification in this build.
   logic        unused_node_id_d;
   assign unused_node_id_d = ^MY_NODE_ID;
`endif

   function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [4:0] idx);
      return base + {10'd0, idx, 1'b0};
   endfunction

   // Scan bookkeeping: clamped count, index increments, end-of-scan and qualification.
   always_comb begin
      n_clamp_d = (neighbor_count > 16'd16) ? NBR_MAX : neighbor_count[4:0];
      i_inc_d   = i_q + 5'd1;
      k_inc_d   = k_q + 5'd1;
      last_d    = (i_inc_d == n_q);
      qualify_d = (qv_q > thr_q) && (k_q < MAX_K);
`ifdef BETTER_NEIGHBOR_SELF_FILTER_EN
      qualify_d = qualify_d && (id_q != me_q);
`endif
   end

   // Scan FSM; every memory-side output is registered on entry to the state that owns it.
   always_ff @(posedge clock or posedge nreset) begin
      if (nreset) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         k_q     <= '0;
         n_q     <= '0;
         thr_q   <= '0;
         id_q    <= '0;
         qv_q    <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
`ifdef BETTER_NEIGHBOR_SELF_FILTER_EN
         me_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               wr_q   <= 1'b0;
               done_q <= 1'b0;
               if (start_betterNeighbor) begin
                  n_q   <= n_clamp_d;
                  thr_q <= _mybest;
                  i_q   <= '0;
                  k_q   <= '0;
`ifdef BETTER_NEIGHBOR_SELF_FILTER_EN
                  me_q  <= MY_NODE_ID;
`endif
                  if (n_clamp_d == 5'd0) begin
                     state_q <= S_WR_CNT;
                     addr_q  <= COUNT_ADDR;
                     dout_q  <= '0;
                     wr_q    <= 1'b1;
                  end else begin
                     state_q <= S_RD_ID;
                     addr_q  <= ID_BASE;
                  end
               end
            end
            // Read data for the address issued in RD_* is valid during CAP_*.
            S_RD_ID: state_q <= S_CAP_ID;
            S_CAP_ID: begin
               id_q    <= data_in;
               addr_q  <= word_addr(Q_BASE, i_q);
               state_q <= S_RD_Q;
            end
            S_RD_Q: state_q <= S_CAP_Q;
            S_CAP_Q: begin
               qv_q    <= data_in;
               state_q <= S_EVAL;
            end
            S_EVAL: begin
               if (qualify_d) begin
                  state_q <= S_WR_ENT;
                  addr_q  <= word_addr(LIST_BASE, k_q);
                  dout_q  <= id_q;
                  wr_q    <= 1'b1;
               end else begin
                  i_q <= i_inc_d;
                  if (last_d) begin
                     state_q <= S_WR_CNT;
                     addr_q  <= COUNT_ADDR;
                     dout_q  <= {11'd0, k_q};
                     wr_q    <= 1'b1;
                  end else begin
                     state_q <= S_RD_ID;
                     addr_q  <= word_addr(ID_BASE, i_inc_d);
                  end
               end
            end
            S_WR_ENT: begin
               k_q <= k_inc_d;
               i_q <= i_inc_d;
               if (last_d) begin
                  state_q <= S_WR_CNT;
                  addr_q  <= COUNT_ADDR;
                  dout_q  <= {11'd0, k_inc_d};
                  wr_q    <= 1'b1;
               end else begin
                  state_q <= S_RD_ID;
                  addr_q  <= word_addr(ID_BASE, i_inc_d);
                  wr_q    <= 1'b0;
               end
            end
            S_WR_CNT: begin
               wr_q    <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               wr_q    <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign address             = addr_q;
   assign data_out            = dout_q;
   assign wr_en               = wr_q;
   assign done_betterNeighbor = done_q;
   assign cstate              = {4'd0, state_q};

endmodule

// File: tb/tb_better_neighbor_writer.sv
// Testbench for better_neighbor_writer: table-backed memory, write log and a list model.
module tb_better_neighbor_writer;

   localparam logic [15:0] ID_BASE    = 16'h0600;
   localparam logic [15:0] Q_BASE     = 16'h0620;
   localparam logic [15:0] LIST_BASE  = 16'h0668;
   localparam logic [15:0] COUNT_ADDR = 16'h068C;

   logic        clock = 1'b0;
   logic        nreset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] ncount = '0;
   logic [15:0] mybest = '0;
   logic [15:0] me = '0;
   logic [15:0] data_in = '0;
   logic [15:0] address, data_out;
   logic        wr_en, done;
   logic [7:0]  cstate;

   logic [15:0] id_tab [16];
   logic [15:0] q_tab  [16];
   logic [15:0] log_a [$];
   logic [15:0] log_d [$];
   int          done_seen = 0;
   logic [15:0] exp_a [$];
   logic [15:0] exp_d [$];
   int          exp_lat;
   int          total = 0;
   int          bad = 0;

   better_neighbor_writer dut (
      .clock(clock), .nreset(nreset), .start_betterNeighbor(start),
      .neighbor_count(ncount), ._mybest(mybest), .MY_NODE_ID(me),
      .data_in(data_in), .address(address), .data_out(data_out),
      .wr_en(wr_en), .done_betterNeighbor(done), .cstate(cstate));

   always #5 clock = ~clock;

   function automatic logic [15:0] rd_word(input logic [15:0] a);
      if (a[15:5] == ID_BASE[15:5]) return id_tab[a[4:1]];
      if (a[15:5] == Q_BASE[15:5])  return q_tab[a[4:1]];
      return 16'hDEAD;
   endfunction

   // Memory: registered read data, writes captured into a log.
   always @(posedge clock) begin
      data_in <= rd_word(address);
      if (wr_en) begin
         log_a.push_back(address);
         log_d.push_back(data_out);
      end
      if (done) done_seen <= done_seen + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: walk the tables and list every neighbor beating the threshold.
   task automatic model(input logic [15:0] ncnt, input logic [15:0] thr, input logic [15:0] mev);
      int nn, cnt;
      bit ok;
      nn  = (ncnt > 16) ? 16 : int'(ncnt);
      cnt = 0;
      exp_a.delete();
      exp_d.delete();
      for (int i = 0; i < nn; i++) begin
         ok = (q_tab[i] > thr) && (cnt < 16);
`ifdef BETTER_NEIGHBOR_SELF_FILTER_EN
         ok = ok && (id_tab[i] != mev);
`else
         if (mev == 16'hFFFF) ok = ok;
`endif
         if (ok) begin
            exp_a.push_back(LIST_BASE + 16'(2 * cnt));
            exp_d.push_back(id_tab[i]);
            cnt++;
         end
      end
      exp_a.push_back(COUNT_ADDR);
      exp_d.push_back(16'(cnt));
      exp_lat = 2 + 5 * nn + cnt + 1;
   endtask

   task automatic do_scan(input logic [15:0] ncnt, input logic [15:0] thr,
                          input logic [15:0] mev, input bit retrig, input string tag);
      int base, d0, lat, nw;
      bit got;
      model(ncnt, thr, mev);
      base = log_a.size();
      d0   = done_seen;
      @(negedge clock);
      ncount = ncnt; mybest = thr; me = mev; start = 1'b1;
      lat = 1; got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         lat++;
         if (c == 2) begin
            ncount = 16'($urandom); mybest = 16'($urandom); me = 16'($urandom);
         end
         if (done) got = 1'b1;
         else if (retrig && c == 4) start = 1'b1;
      end
      start = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      chk({tag, " done_seen"}, 32'(got), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      nw = log_a.size() - base;
      chk({tag, " write_count"}, 32'(nw), 32'(exp_a.size()));
      for (int j = 0; j < exp_a.size() && j < nw; j++) begin
         chk($sformatf("%s wr%0d_addr", tag, j), 32'(log_a[base + j]), 32'(exp_a[j]));
         chk($sformatf("%s wr%0d_data", tag, j), 32'(log_d[base + j]), 32'(exp_d[j]));
      end
      chk({tag, " done_pulses"}, 32'(done_seen - d0), 32'd1);
   endtask

   task automatic rand_tables();
      for (int i = 0; i < 16; i++) begin
         id_tab[i] = 16'($urandom);
         q_tab[i]  = 16'($urandom);
      end
   endtask

   initial begin
      int base;
      bit hit;
      rand_tables();
      #3;
      chk("rst address", 32'(address), 32'd0);
      chk("rst data_out", 32'(data_out), 32'd0);
      chk("rst wr_en", 32'(wr_en), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst cstate", 32'(cstate), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock) nreset = 1'b0;

      // Directed three-neighbor example.
      id_tab[0] = 16'd5;  id_tab[1] = 16'd7;  id_tab[2] = 16'd9;
      q_tab[0]  = 16'd10; q_tab[1]  = 16'd30; q_tab[2]  = 16'd20;
      do_scan(16'd3, 16'd15, 16'd0, 1'b0, "basic");

      do_scan(16'd0, 16'd0, 16'd0, 1'b0, "n0");

      // Overlong count, everything qualifies: list fills to capacity.
      for (int i = 0; i < 16; i++) begin
         id_tab[i] = 16'($urandom); q_tab[i] = 16'hFFFF;
      end
      do_scan(16'd20, 16'd0, 16'd0, 1'b0, "full");

      // Own ID present among neighbors.
      id_tab[0] = 16'd3;  id_tab[1] = 16'd1;
      q_tab[0]  = 16'd50; q_tab[1]  = 16'd50;
      do_scan(16'd2, 16'd10, 16'd3, 1'b0, "self");

      // Equal Q-value does not qualify.
      id_tab[0] = 16'd11; q_tab[0] = 16'd40;
      id_tab[1] = 16'd12; q_tab[1] = 16'd41;
      do_scan(16'd2, 16'd40, 16'd0, 1'b0, "equal");

      rand_tables();
      do_scan(16'd6, 16'h4000, 16'd0, 1'b1, "retrig");

      for (int r = 0; r < 8; r++) begin
         rand_tables();
         do_scan(16'($urandom_range(0, 20)), 16'($urandom), id_tab[$urandom_range(0, 15)],
                 1'b0, $sformatf("rand%0d", r));
      end

      // Reset in the middle of a scan.
      rand_tables();
      @(negedge clock);
      ncount = 16'd4; mybest = 16'd0; start = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (cstate == 8'd3) hit = 1'b1;
      end
      chk("midrst reached_rd_q", 32'(hit), 32'd1);
      #2;
      nreset = 1'b1;
      #1;
      chk("midrst address", 32'(address), 32'd0);
      chk("midrst data_out", 32'(data_out), 32'd0);
      chk("midrst wr_en", 32'(wr_en), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst cstate", 32'(cstate), 32'd0);
      base = log_a.size();
      repeat (2) @(posedge clock);
      @(negedge clock) nreset = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      chk("midrst no_writes", 32'(log_a.size() - base), 32'd0);
      chk("midrst idle", 32'(cstate), 32'd0);

      // Scanner still works after the abort.
      id_tab[0] = 16'd21; q_tab[0] = 16'd9;
      do_scan(16'd1, 16'd8, 16'd0, 1'b0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
